// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and BCD helpers for the lap stopwatch
package stopwatch_pkg;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  typedef struct packed {
    logic [3:0] mm_hi;
    logic [3:0] mm_lo;
    logic [3:0] ss_hi;
    logic [3:0] ss_lo;
    logic [3:0] cc_hi;
    logic [3:0] cc_lo;
  } lap_time_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  // One cascade stage: {carry_out, next_digit}.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] max_d,
                                          input logic cin);
    if (!cin)
      return {1'b0, d};
    else if (d == max_d)
      return 5'b1_0000;
    else
      return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser, stability filter and press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Counter tracks consecutive samples that disagree with the accepted level.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg.sv
// rtl/sevenseg.sv - BCD to active-low seven-segment decoder, {g,f,e,d,c,b,a}
module sevenseg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    unique case (digit)
      4'd0:    seg = 7'b100_0000;
      4'd1:    seg = 7'b111_1001;
      4'd2:    seg = 7'b010_0100;
      4'd3:    seg = 7'b011_0000;
      4'd4:    seg = 7'b001_1001;
      4'd5:    seg = 7'b001_0010;
      4'd6:    seg = 7'b000_0010;
      4'd7:    seg = 7'b111_1000;
      4'd8:    seg = 7'b000_0000;
      4'd9:    seg = 7'b001_0000;
      default: seg = 7'b111_1111;
    endcase
  end
endmodule

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - mm:ss:cc stopwatch with circular lap memory and recall
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 5000000,
  parameter int LAP_DEPTH       = 4
) (
  input  logic       clk,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_lap,
  input  logic       key_display_stop,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       led3
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = CW + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(LAP_DEPTH);
  localparam logic [AW-1:0] PTR_LAST   = AW'(LAP_DEPTH - 1);

  logic start_p, lap_p, recall_p;

  sw_state_t     state, state_n;
  logic [PW-1:0] presc;
  logic          tick;
  lap_time_t     cur_time, time_inc, shown, shown_q;
  logic          wrap, ovf;
  lap_time_t     laps [LAP_DEPTH];
  logic [AW-1:0] wr_ptr, rd_idx;
  logic [CW-1:0] count, count_after;
  logic [CW-1:0] view, view_after, view_n;
  logic [IW-1:0] rd_sum;
  logic          push, clear;
  logic [4:0]    c0, c1, c2, c3, c4, c5;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .clk(clk), .resetn(key_reset), .key_raw(key_start_pause), .press(start_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
    .clk(clk), .resetn(key_reset), .key_raw(key_lap), .press(lap_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_recall (
    .clk(clk), .resetn(key_reset), .key_raw(key_display_stop), .press(recall_p));

  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

  always_comb begin
    c0 = bcd_step(cur_time.cc_lo, BCD_MAX9, 1'b1);
    c1 = bcd_step(cur_time.cc_hi, BCD_MAX9, c0[4]);
    c2 = bcd_step(cur_time.ss_lo, BCD_MAX9, c1[4]);
    c3 = bcd_step(cur_time.ss_hi, BCD_MAX5, c2[4]);
    c4 = bcd_step(cur_time.mm_lo, BCD_MAX9, c3[4]);
    c5 = bcd_step(cur_time.mm_hi, BCD_MAX5, c4[4]);
    time_inc.cc_lo = c0[3:0];
    time_inc.cc_hi = c1[3:0];
    time_inc.ss_lo = c2[3:0];
    time_inc.ss_hi = c3[3:0];
    time_inc.mm_lo = c4[3:0];
    time_inc.mm_hi = c5[3:0];
    wrap = c5[4];
  end

  // Events resolve in the order start, lap, recall; each sees the result of the previous.
  always_comb begin
    state_n = state;
    if (start_p) begin
      unique case (state)
        ST_IDLE: state_n = ST_RUN;
        ST_RUN:  state_n = ST_PAUSE;
        default: state_n = ST_RUN;
      endcase
    end
    push        = lap_p && (state_n == ST_RUN);
    clear       = lap_p && (state_n == ST_PAUSE);
    count_after = count;
    view_after  = view;
    if (clear) begin
      count_after = '0;
      view_after  = '0;
    end else if (push) begin
      if (count != COUNT_FULL) count_after = count + 1'b1;
      view_after = '0;
    end
    view_n = view_after;
    if (recall_p) view_n = (view_after >= count_after) ? '0 : view_after + 1'b1;
  end

  always_comb begin
    rd_sum = IW'(wr_ptr) + IW'(LAP_DEPTH) - IW'(view);
    rd_idx = (rd_sum >= IW'(LAP_DEPTH)) ? AW'(rd_sum - IW'(LAP_DEPTH)) : AW'(rd_sum);
    shown  = (view == '0) ? cur_time : laps[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!key_reset) begin
      state    <= ST_IDLE;
      presc    <= '0;
      cur_time <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      count    <= '0;
      view     <= '0;
      shown_q  <= '0;
    end else begin
      shown_q <= shown;
      view    <= view_n;
      count   <= count_after;
      if (clear) begin
        state    <= ST_IDLE;
        presc    <= '0;
        cur_time <= '0;
        ovf      <= 1'b0;
        wr_ptr   <= '0;
      end else begin
        state <= state_n;
        if (tick) begin
          presc    <= '0;
          cur_time <= time_inc;
          if (wrap) ovf <= 1'b1;
        end else if (state == ST_RUN) begin
          presc <= presc + 1'b1;
        end
        if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
    end
  end

  // Lap storage captures the pre-tick time; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (key_reset && push) laps[wr_ptr] <= cur_time;
  end

  assign led0 = (state == ST_RUN);
  assign led1 = (view != '0);
  assign led2 = (count == COUNT_FULL);
  assign led3 = ovf;

  sevenseg u_seg0 (.digit(shown_q.cc_lo), .seg(hex0));
  sevenseg u_seg1 (.digit(shown_q.cc_hi), .seg(hex1));
  sevenseg u_seg2 (.digit(shown_q.ss_lo), .seg(hex2));
  sevenseg u_seg3 (.digit(shown_q.ss_hi), .seg(hex3));
  sevenseg u_seg4 (.digit(shown_q.mm_lo), .seg(hex4));
  sevenseg u_seg5 (.digit(shown_q.mm_hi), .seg(hex5));

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised successor to the board stopwatch: mm:ss:cc timer with a synchronous BCD digit cascade instead of divide/modulo. Adds a circular lap memory of configurable depth, lap recall, run/idle LEDs and a sticky overflow flag. Drives the six on-board seven-segment digits through the existing sevenseg decoder. It is the top-level block on the DE1-SoC; all keys are active-low.

Parameters:
TICK_DIV, 500000, clk cycles per 10 ms tick (50 MHz); benches use 4
DEBOUNCE_CYCLES, 5000000, consecutive stable cycles before a key level is accepted; benches use 3
LAP_DEPTH, 4, lap entries stored (2..16)

Ports:
clk  in  1  system clock, single domain
key_reset  in  1  synchronous active-low reset (raw, not debounced)
key_start_pause  in  1  key, low = pressed: toggle run/pause
key_lap  in  1  key: lap capture when running, clear when paused
key_display_stop  in  1  key: recall, steps through stored laps
hex0..hex5  out  7 each  segments cc_lo, cc_hi, ss_lo, ss_hi, mm_lo, mm_hi
led0  out  1  running
led1  out  1  recall view active
led2  out  1  lap buffer full
led3  out  1  sticky overflow (59:59.99 wrapped)

Behaviour:
- Reset: key_reset low at a clk edge clears, on that edge, all digits, prescaler, lap buffer (count=0, write ptr=0), recall index, overflow flag, debouncers (accepted level=1). State=IDLE, live view, all LEDs 0, hex shows 00:00:00. Applies mid-operation with priority over every key event.
- Key path: 2-flop synchroniser -> debouncer. Accepted level changes after DEBOUNCE_CYCLES consecutive equal synchronised samples. A press is an accepted 1->0 transition and yields a 1-cycle pulse. Releases produce no event. Latency from raw edge to pulse: DEBOUNCE_CYCLES+2 cycles.
- States: IDLE (zero, stopped), RUN, PAUSE.
  - start pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - lap pulse in RUN: push the current time.
  - lap pulse in PAUSE: clear digits, prescaler, lap buffer and overflow; ->IDLE.
  - lap pulse in IDLE: ignored.
- Prescaler counts 0..TICK_DIV-1 only in RUN. tick=1 on the cycle it equals TICK_DIV-1; it then returns to 0. Prescaler holds its value in PAUSE.
- Digit cascade on tick: cc_lo 0-9, cc_hi 0-9, ss_lo 0-9, ss_hi 0-5, mm_lo 0-9, mm_hi 0-5. Carry ripples combinationally and all digits update on the same edge. 59:59.99 + tick -> 00:00.00, overflow flag set, timer keeps running.
- Lap buffer: LAP_DEPTH x 24-bit (6 BCD digits), circular.
  - Push writes at write ptr, then ptr++ mod LAP_DEPTH. count saturates at LAP_DEPTH.
  - When full, the oldest entry is overwritten. led2 = (count==LAP_DEPTH).
- Recall: view index v. 0 = live, k = k-th newest lap.
  - recall pulse: v++. If v would exceed count, v returns to 0 (live). With count=0 recall stays live.
  - led1 = (v!=0).
  - A push while v!=0 sets v=0. A clear sets v=0.
  - Counting continues during recall.
- Display mux: v=0 shows live digits; otherwise shows lap entry (wr_ptr - v) mod LAP_DEPTH. Output is registered, 1 cycle after digit/index update.
- led0=1 in RUN only.
- Same-cycle events are processed in order start, lap, recall. lap and recall act on the post-start state: e.g. start+lap in RUN -> PAUSE then clear.
- Tick and lap push on the same cycle: the stored value is the pre-tick time.

Decomposition:
- Package stopwatch_pkg:
  - BCD digit limits (9, 5).
  - 24-bit time type as six 4-bit fields.
  - State encoding IDLE/RUN/PAUSE.
- Sub-module key_debounce (param DEBOUNCE_CYCLES): synchroniser, stability counter, press pulse. Instantiated 3 times.
- The existing sevenseg decoder is reused, 6 instances.

Test Plan:
TICK_DIV=4, DEBOUNCE_CYCLES=3 throughout.
1. Reset then press start; run 400 cycles -> 100 ticks, display 00:01:00, led0=1. Press start again -> value frozen, led0=0.
2. Force digits to 59:59:98 in RUN; apply 2 ticks -> 00:00:00, led3=1. led3 stays 1 after pause; clear via lap-in-PAUSE -> led3=0.
3. Key bounce: key low 2 cycles, high 1, low 5 -> exactly one start pulse, emitted 5 cycles after the final low edge.
4. Five lap presses at 00:00:01, :02, :03, :04, :05 with LAP_DEPTH=4 -> led2=1. Four recalls show :05, :04, :03, :02 (led1=1); fifth recall -> live, led1=0.
5. Recall on lap 2, then lap press while running -> view returns to live (v=0) and the new lap becomes newest.
6. Assert key_reset low for 1 cycle mid-RUN with laps stored -> next cycle hex=00:00:00, all LEDs 0, recall shows live.
